// File: rtl/button_gesture_pkg.sv
// Shared types and default timing constants for the button gesture decoder.
package button_gesture_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_HELD1 = 3'd1,
        ST_WAIT2 = 3'd2,
        ST_HELD2 = 3'd3,
        ST_LONG  = 3'd4
    } gesture_state_t;

    localparam int DEF_CNT_W        = 26;
    localparam int DEF_LONG_TICKS   = 50_000_000;
    localparam int DEF_DCLICK_TICKS = 12_500_000;
    localparam int DEF_REPEAT_TICKS = 5_000_000;

endpackage

// File: rtl/button_gesture_decoder_edge.sv
// Rise/fall detection on the debounced level; rises are suppressed until the
// button has been seen released once after reset.
module button_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic btn_prev,
    output logic rise,
    output logic fall
);

    logic prev_r;
    logic armed_r;

    // Previous-level register and one-shot arming flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            prev_r <= btn_level;
            if (!btn_level) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    assign btn_prev = prev_r;
    assign rise     = btn_level & ~prev_r & armed_r;
    assign fall     = ~btn_level & prev_r;

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies debounced presses into short/double/long events.
// Define BUTTON_GESTURE_AUTOREPEAT_EN to enable repeat_pulse while held long.
module button_gesture_decoder
    import button_gesture_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic btn_pressed,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_pulse
);

`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
    localparam logic REPEAT_EN = 1'b1;
`else
    localparam logic REPEAT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DCLICK_M1 = CNT_W'(DCLICK_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_M1 = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    gesture_state_t   state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             rise_s;
    logic             fall_s;
    logic             short_r;
    logic             double_r;
    logic             long_r;
    logic             repeat_r;

    button_edge_detect u_edge (
        .clk       (clk),
        .reset     (reset),
        .btn_level (btn_level),
        .btn_prev  (btn_pressed),
        .rise      (rise_s),
        .fall      (fall_s)
    );

    // Saturating increment so a long idle period cannot wrap the counter.
    always_comb begin
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_W'(1);
        end
    end

    // Gesture FSM with timing counter and registered event pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            short_r  <= 1'b0;
            double_r <= 1'b0;
            long_r   <= 1'b0;
            repeat_r <= 1'b0;
        end else begin
            short_r  <= 1'b0;
            double_r <= 1'b0;
            long_r   <= 1'b0;
            repeat_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_r <= ST_HELD1;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_HELD1: begin
                    if (fall_s) begin
                        state_r <= ST_WAIT2;
                        cnt_r   <= '0;
                    end else if (cnt_r == LONG_M1) begin
                        state_r <= ST_LONG;
                        cnt_r   <= '0;
                        long_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_WAIT2: begin
                    // Gap timeout beats a coincident rise; that rise starts a new gesture.
                    if (cnt_r == DCLICK_M1) begin
                        short_r <= 1'b1;
                        cnt_r   <= '0;
                        state_r <= rise_s ? ST_HELD1 : ST_IDLE;
                    end else if (rise_s) begin
                        state_r <= ST_HELD2;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_HELD2: begin
                    if (fall_s) begin
                        state_r  <= ST_IDLE;
                        cnt_r    <= '0;
                        double_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_LONG: begin
                    if (fall_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else if (REPEAT_EN && (cnt_r == REPEAT_M1)) begin
                        cnt_r    <= '0;
                        repeat_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign short_press  = short_r;
    assign double_press = double_r;
    assign long_press   = long_r;
    assign repeat_pulse = repeat_r;

endmodule
